// File: rtl/lcd_seq_driver.sv
// HD44780 sequencer: optional power-up init, then walks the 16-word script ROM and drives the LCD bus.
// Build option LCD_INIT_EN: when defined, POR wait plus controller init run after every reset.
module lcd_seq_driver #(
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int POR_WAIT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] rom_addr,
    input  logic [8:0] rom_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       done
);
    localparam int MAX_A   = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
    localparam int MAX_B   = (CLR_WAIT_CYC > POR_WAIT_CYC) ? CLR_WAIT_CYC : POR_WAIT_CYC;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] E_LOAD   = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
    localparam logic [CW-1:0] POR_LOAD = CW'(POR_WAIT_CYC - 1);
`endif

    typedef enum logic [3:0] {
`ifdef LCD_INIT_EN
        POR_WAIT, INIT_SETUP, INIT_E_HIGH, INIT_E_HOLD, INIT_WAIT,
`endif
        IDLE, FETCH, SETUP, E_HIGH, E_HOLD, WAIT, DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    addr, addr_nx;
    logic          word_rs, word_rs_nx;
    logic [7:0]    word_db, word_db_nx;
    logic [CW-1:0] wait_load;
    logic          e_nx;

`ifdef LCD_INIT_EN
    logic [2:0] init_idx, init_idx_nx;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd3:    init_byte = 8'h0C;
            3'd4:    init_byte = 8'h01;
            3'd5:    init_byte = 8'h06;
            default: init_byte = 8'h38;
        endcase
    endfunction
`endif

    // Clear-display and return-home need the long controller settle time.
    assign wait_load = (!word_rs && (word_db == 8'h01 || word_db == 8'h02 || word_db == 8'h03))
                       ? CLR_LOAD : CMD_LOAD;

    // start is a level request: only looked at in IDLE; busy rising is the acknowledge.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        addr_nx    = addr;
        word_rs_nx = word_rs;
        word_db_nx = word_db;
`ifdef LCD_INIT_EN
        init_idx_nx = init_idx;
`endif
        case (state)
`ifdef LCD_INIT_EN
            POR_WAIT: begin
                if (cnt == '0) begin
                    state_nx   = INIT_SETUP;
                    word_rs_nx = 1'b0;
                    word_db_nx = init_byte(init_idx);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            INIT_SETUP: begin
                state_nx = INIT_E_HIGH;
                cnt_nx   = E_LOAD;
            end
            INIT_E_HIGH: begin
                if (cnt == '0) state_nx = INIT_E_HOLD;
                else           cnt_nx   = cnt - CW'(1);
            end
            INIT_E_HOLD: begin
                state_nx = INIT_WAIT;
                cnt_nx   = wait_load;
            end
            INIT_WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else if (init_idx == 3'd5) begin
                    state_nx = IDLE;
                end else begin
                    init_idx_nx = init_idx + 3'd1;
                    state_nx    = INIT_SETUP;
                    word_db_nx  = init_byte(init_idx + 3'd1);
                end
            end
`endif
            IDLE: begin
                addr_nx = 4'd0;
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                state_nx   = SETUP;
                word_rs_nx = rom_data[8];
                word_db_nx = rom_data[7:0];
            end
            SETUP: begin
                state_nx = E_HIGH;
                cnt_nx   = E_LOAD;
            end
            E_HIGH: begin
                if (cnt == '0) state_nx = E_HOLD;
                else           cnt_nx   = cnt - CW'(1);
            end
            E_HOLD: begin
                state_nx = WAIT;
                cnt_nx   = wait_load;
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else if (addr == 4'd15) begin
                    state_nx = DONE;
                end else begin
                    addr_nx  = addr + 4'd1;
                    state_nx = FETCH;
                end
            end
            DONE: begin
                state_nx = IDLE;
                addr_nx  = 4'd0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        e_nx = (state_nx == E_HIGH);
`ifdef LCD_INIT_EN
        if (state_nx == INIT_E_HIGH) e_nx = 1'b1;
`endif
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            state    <= POR_WAIT;
            cnt      <= POR_LOAD;
            init_idx <= 3'd0;
            busy     <= 1'b1;
`else
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
`endif
            addr     <= 4'd0;
            word_rs  <= 1'b0;
            word_db  <= 8'h00;
            lcd_e    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
`ifdef LCD_INIT_EN
            init_idx <= init_idx_nx;
`endif
            busy     <= (state_nx != IDLE);
            addr     <= addr_nx;
            word_rs  <= word_rs_nx;
            word_db  <= word_db_nx;
            lcd_e    <= e_nx;
            done     <= (state_nx == DONE);
        end
    end

    assign rom_addr = addr;
    assign lcd_rs   = word_rs;
    assign lcd_db   = word_db;
    assign lcd_rw   = 1'b0;

endmodule
